// File: rtl/gpio_pkg.sv
// gpio_pkg: shared definitions for the Wishbone GPIO port.
//   - register offset constants (word offset = adr_i[3:2])
//   - edge_mode_t: which debounced transitions set EDGE bits
//   - wb_state_t: bus response FSM states
//   - byteMask/byteMerge: byte-lane helpers for sel_i-qualified writes
package gpio_pkg;

  localparam logic [1:0] GPIO_OUT   = 2'd0;
  localparam logic [1:0] GPIO_IN    = 2'd1;
  localparam logic [1:0] GPIO_EDGE  = 2'd2;
  localparam logic [1:0] GPIO_IRQEN = 2'd3;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } wb_state_t;

  // Expands the four byte enables into a 32-bit lane mask.
  function automatic logic [31:0] byteMask(input logic [3:0] sel);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{sel[i]}};
    end
    return mask;
  endfunction

  // Replaces the enabled byte lanes of oldVal with those of newVal.
  function automatic logic [31:0] byteMerge(input logic [31:0] oldVal,
                                            input logic [31:0] newVal,
                                            input logic [3:0]  sel);
    logic [31:0] mask;
    mask = byteMask(sel);
    return (oldVal & ~mask) | (newVal & mask);
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: per-bit input conditioning for the GPIO input port.
//   Each bit passes a 2-flop synchroniser, then a debouncer that accepts a
//   new level only after it has differed from the current stable level for
//   CYCLES+1 consecutive clocks (CYCLES=0 leaves just the synchroniser plus
//   one register stage).
// Ports:
//   clock, reset  - block clock, synchronous active-high reset
//   i_raw         - asynchronous raw inputs
//   o_stable      - debounced level
//   o_changed     - one-cycle pulse on bits whose o_stable just changed
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int CYCLES = 16,
  parameter int WIDTH  = 13
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_stable,
  output logic [WIDTH-1:0] o_changed
);

  localparam int CW = (CYCLES > 0) ? $clog2(CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(CYCLES);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_changed;
  logic [CW-1:0]    r_count [WIDTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // The counter only runs while the synchronised level disagrees with the
  // stable level; any agreement restarts it, so short glitches die out.
  // Reaching LIMIT commits the new level and clears the counter, so it can
  // never wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stable  <= '0;
      r_changed <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        r_changed[i] <= 1'b0;
        if (r_sync2[i] == r_stable[i]) begin
          r_count[i] <= '0;
        end else if (r_count[i] == LIMIT) begin
          r_stable[i]  <= r_sync2[i];
          r_changed[i] <= 1'b1;
          r_count[i]   <= '0;
        end else begin
          r_count[i] <= r_count[i] + CW'(1);
        end
      end
    end
  end

  assign o_stable  = r_stable;
  assign o_changed = r_changed;

endmodule

// File: rtl/wb_gpio_port.sv
// wb_gpio_port: Wishbone GPIO slave with output port, debounced input port,
// per-bit edge capture and a maskable level interrupt.
//   Registers (word offset adr_i[3:2]): 0 OUT rw, 1 IN ro, 2 EDGE w1c,
//   3 IRQ_EN rw. Bits above the port widths read 0 and ignore writes.
// Ports:
//   clock, reset          - bus/block clock, synchronous active-high reset
//   adr_i, dat_i, sel_i,
//   we_i, stb_i, cyc_i    - Wishbone request
//   dat_o, ack_o, err_o   - Wishbone response (registered, one cycle)
//   gpio_in               - raw asynchronous inputs
//   gpio_out              - registered output port
//   irq                   - registered OR of EDGE & IRQ_EN
module wb_gpio_port
  import gpio_pkg::*;
#(
  parameter int          OUT_WIDTH       = 10,
  parameter int          IN_WIDTH        = 13,
  parameter logic [31:0] RESET_PAT       = 32'h0,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [1:0]  EDGE_MODE       = 2'b01
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          adr_i,
  input  logic [31:0]          dat_i,
  input  logic [3:0]           sel_i,
  input  logic                 we_i,
  input  logic                 stb_i,
  input  logic                 cyc_i,
  output logic [31:0]          dat_o,
  output logic                 ack_o,
  output logic                 err_o,
  input  logic [IN_WIDTH-1:0]  gpio_in,
  output logic [OUT_WIDTH-1:0] gpio_out,
  output logic                 irq
);

  localparam logic [OUT_WIDTH-1:0] OUT_RESET = RESET_PAT[OUT_WIDTH-1:0];
  localparam edge_mode_t MODE    = edge_mode_t'(EDGE_MODE);
  localparam bit         RISE_EN = (MODE == EDGE_RISE) || (MODE == EDGE_BOTH);
  localparam bit         FALL_EN = (MODE == EDGE_FALL) || (MODE == EDGE_BOTH);

  wb_state_t r_state;
  wb_state_t w_nextState;

  logic [OUT_WIDTH-1:0] r_out;
  logic [IN_WIDTH-1:0]  r_edge;
  logic [IN_WIDTH-1:0]  r_irqEn;
  logic                 r_irq;
  logic                 r_ack;
  logic                 r_err;
  logic [31:0]          r_dat;

  logic [IN_WIDTH-1:0]  w_stable;
  logic [IN_WIDTH-1:0]  w_changed;
  logic [IN_WIDTH-1:0]  w_edgeSet;
  logic [IN_WIDTH-1:0]  w_edgeClr;
  logic                 w_request;
  logic [1:0]           w_offset;
  logic [31:0]          w_readData;
  logic                 w_ackNext;
  logic                 w_errNext;
  logic [31:0]          w_datNext;
  logic                 w_doWrite;
  logic                 w_unusedAdr;

  gpio_debounce #(
    .CYCLES (DEBOUNCE_CYCLES),
    .WIDTH  (IN_WIDTH)
  ) u_debounce (
    .clock     (clock),
    .reset     (reset),
    .i_raw     (gpio_in),
    .o_stable  (w_stable),
    .o_changed (w_changed)
  );

  assign w_request   = cyc_i & stb_i;
  assign w_offset    = adr_i[3:2];
  assign w_unusedAdr = ^{adr_i[31:4], adr_i[1:0]};

  always_comb begin
    w_readData = '0;
    case (w_offset)
      GPIO_OUT:   w_readData[OUT_WIDTH-1:0] = r_out;
      GPIO_IN:    w_readData[IN_WIDTH-1:0]  = w_stable;
      GPIO_EDGE:  w_readData[IN_WIDTH-1:0]  = r_edge;
      GPIO_IRQEN: w_readData[IN_WIDTH-1:0]  = r_irqEn;
    endcase
  end

  // Sitting in RESP for the response cycle blocks a held strobe from being
  // sampled again, giving one response every two cycles.
  always_comb begin
    w_nextState = r_state;
    w_ackNext   = 1'b0;
    w_errNext   = 1'b0;
    w_datNext   = '0;
    w_doWrite   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_request) begin
          w_nextState = RESP;
          if (we_i && (w_offset == GPIO_IN)) begin
            w_errNext = 1'b1;
          end else begin
            w_ackNext = 1'b1;
            w_datNext = w_readData;
            w_doWrite = we_i;
          end
        end
      end
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Listing the set term last in the EDGE update makes a new edge win over
  // a simultaneous write-1-to-clear of the same bit.
  assign w_edgeClr = (w_doWrite && (w_offset == GPIO_EDGE))
                   ? IN_WIDTH'(dat_i & byteMask(sel_i)) : '0;
  assign w_edgeSet = w_changed & (({IN_WIDTH{RISE_EN}} & w_stable) |
                                  ({IN_WIDTH{FALL_EN}} & ~w_stable));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= '0;
      r_out   <= OUT_RESET;
      r_edge  <= '0;
      r_irqEn <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_ack <= w_ackNext;
      r_err <= w_errNext;
      r_dat <= w_datNext;
      if (w_doWrite && (w_offset == GPIO_OUT)) begin
        r_out <= OUT_WIDTH'(byteMerge(32'(r_out), dat_i, sel_i));
      end
      if (w_doWrite && (w_offset == GPIO_IRQEN)) begin
        r_irqEn <= IN_WIDTH'(byteMerge(32'(r_irqEn), dat_i, sel_i));
      end
      r_edge <= (r_edge & ~w_edgeClr) | w_edgeSet;
      r_irq  <= |(r_edge & r_irqEn);
    end
  end

  assign dat_o    = r_dat;
  assign ack_o    = r_ack;
  assign err_o    = r_err;
  assign gpio_out = r_out;
  assign irq      = r_irq;

endmodule

// File: doc/wb_gpio_port.md
Name: wb_gpio_port

Overview:
- Parametrised Wishbone GPIO slave; successor to the fixed 32-bit LED output register.
- Combines in one block:
  - a configurable-width output port (LEDs),
  - a debounced input port (switches, buttons),
  - per-bit edge capture,
  - a maskable interrupt line into the processor interrupt vector.
- Sits on the processor data bus behind an address-decoded connect, same as other data-bus peripherals.

Parameters:
- OUT_WIDTH, 10, output port width (1..32).
- IN_WIDTH, 13, input port width (1..32).
- RESET_PAT, 32'h0, reset value of OUT register; truncated to OUT_WIDTH.
- DEBOUNCE_CYCLES, 16, consecutive stable clocks needed to accept an input change; 0 = no debounce (synchroniser only).
- EDGE_MODE, 2'b01, edges that set EDGE bits: 01 rising, 10 falling, 11 both, 00 none.

Ports:
- clock  input  1  bus and block clock.
- reset  input  1  synchronous, active-high reset.
- bus  interface  wishboneSlave.slave  uses adr_i, dat_i, dat_o, sel_i, we_i, stb_i, cyc_i, ack_o, err_o.
- gpio_in  input  IN_WIDTH  raw asynchronous inputs.
- gpio_out  output  OUT_WIDTH  registered output port.
- irq  output  1  level interrupt, registered.

Behaviour:
- Register map: word offset = adr_i[3:2]. Upper address bits are ignored; the connect decodes them.
  - 0 OUT: read/write.
  - 1 IN: read-only, debounced value.
  - 2 EDGE: write-1-to-clear.
  - 3 IRQ_EN: read/write.
- Bits above the relevant width read as 0; writes to them are ignored.
- Bus handshake:
  - Request = cyc_i & stb_i.
  - ack_o or err_o is registered and asserts exactly one cycle after a request is sampled with no response pending.
  - The response is held one cycle only, then drops.
  - A master holding stb gets one response every 2 cycles.
  - dat_o is valid in the ack cycle; otherwise it is 0.
- Errors:
  - A write to IN gives err_o instead of ack_o, with no state change.
  - All other accesses ack.
- Byte enables: writes honour sel_i[3:0] per byte for OUT, EDGE-clear and IRQ_EN.
- Write timing: register update takes effect on the same edge that asserts ack_o. gpio_out changes on that edge.
- Input path, per bit:
  - 2-flop synchroniser, then the debouncer.
  - The debouncer has a stable register and a counter of width clog2(DEBOUNCE_CYCLES+1).
  - The counter increments while the synchronised value differs from the stable value, and clears when they match.
  - When the count reaches DEBOUNCE_CYCLES, the stable value takes the synchronised value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never propagates.
- Input latency: raw change to IN-register change = 2 + DEBOUNCE_CYCLES + 1 clocks.
- Edge capture:
  - On a stable-value transition matching EDGE_MODE, the corresponding EDGE bit sets on the next clock.
  - A set and a W1C clear of the same bit in the same cycle: set wins.
- irq: registered OR of (EDGE & IRQ_EN); 1-cycle lag after the EDGE/IRQ_EN change.
- Reset values:
  - OUT and gpio_out = RESET_PAT[OUT_WIDTH-1:0].
  - EDGE = 0, IRQ_EN = 0, irq = 0.
  - ack_o = 0, err_o = 0, dat_o = 0.
  - Synchroniser and stable registers = 0; counters = 0.
  - Reset does not generate edges.
- Reset mid-transaction: a pending response is dropped and no write occurs. The master must re-issue the request after reset.
- Counter wrap: impossible, because the count saturates at DEBOUNCE_CYCLES via the clear.

Decomposition:
- Shared package gpio_pkg:
  - register offset constants GPIO_OUT=2'd0, GPIO_IN=2'd1, GPIO_EDGE=2'd2, GPIO_IRQEN=2'd3;
  - edge_mode_t enum (EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH);
  - a byte-mask merge function.
- One sub-module gpio_debounce:
  - parameters CYCLES and WIDTH;
  - contains the synchroniser, per-bit counters and stable registers;
  - outputs the stable value and a one-cycle changed-bit vector.
- Top-level wb_gpio_port holds the register file, edge logic, irq and the Wishbone FSM.
- Wishbone FSM states: IDLE, RESP. IDLE goes to RESP on request; RESP always returns to IDLE.

Test Plan:
- Reset with RESET_PAT=32'h11335577, OUT_WIDTH=10 -> gpio_out=10'h177. Read offset 0 -> dat_o=32'h177, ack_o one cycle after stb, irq=0.
- Write offset 0, dat 32'hFFFF_FFFF, sel 4'b0001 -> gpio_out=10'h1FF. Then write offset 1 -> err_o=1, ack_o=0, IN unchanged.
- DEBOUNCE_CYCLES=16: pulse gpio_in[3] high 10 clocks -> IN stays 0, EDGE=0. Hold high 30 clocks -> IN bit 3 sets exactly 19 clocks after the rise, EDGE[3]=1.
- IRQ_EN=32'h8, rising edge on bit 3 -> irq asserts 1 clock after EDGE[3]. Write 32'h8 to offset 2 -> EDGE[3]=0, irq drops next clock.
- W1C of EDGE[3] in the same cycle as a new rising edge on bit 3 -> EDGE[3] stays 1.
- Assert reset during a request, in the cycle before ack -> no ack_o, OUT keeps its reset value. A request after reset acks normally.
